ps2_glyph_rx: RTL and testbench

PS/2 keyboard receiver for the DE1 seven-segment message path. It deserialises device-to-host PS/2 frames and filters out break and extended codes. Mapped make codes are translated into active-low 7-segment glyphs, which shift into a 4-digit buffer that drives HEX0..HEX3 directly. The display side stays unchanged: this block is the input end that types the message instead of hard-coding it.

---
 rtl/ps2_glyph_rx_if.sv | 24 ++
 rtl/ps2_glyph_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ps2_glyph_rx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_glyph_rx_if.sv
// Pin and result bundle for the PS/2 glyph receiver.
// master is the receiver side; slave is the board/pin side.
`timescale 1ns/1ps
interface ps2_glyph_rx_if #(
  parameter int DIGITS = 4
);
  logic                  ps2_clk;
  logic                  ps2_dat;
  logic [7:0]            code;
  logic                  code_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic [7*DIGITS-1:0]   glyph_bus;

  modport master (
    input  ps2_clk, ps2_dat,
    output code, code_valid, parity_err, frame_err, glyph_bus
  );

  modport slave (
    output ps2_clk, ps2_dat,
    input  code, code_valid, parity_err, frame_err, glyph_bus
  );
endinterface

// File: rtl/ps2_glyph_rx.sv
// PS/2 device-to-host receiver: frames bytes, drops break/extended codes, and
// shifts the mapped glyphs into an active-low 7-segment message buffer.
`timescale 1ns/1ps
module ps2_glyph_rx #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DIGITS         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ps2_glyph_rx_if.master  bus
);
  localparam int GW = 7 * DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronisers idle high so reset release never fakes a falling edge.
  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= bus.ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          timeout;
  logic          ev_good_nxt, ev_perr_nxt, ev_ferr_nxt;
  logic          ev_good, ev_perr, ev_ferr;
  logic [7:0]    ev_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
      ev_good <= 1'b0;
      ev_perr <= 1'b0;
      ev_ferr <= 1'b0;
      ev_byte <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      tmo_cnt <= tmo_nxt;
      ev_good <= ev_good_nxt;
      ev_perr <= ev_perr_nxt;
      ev_ferr <= ev_ferr_nxt;
      if (ev_good_nxt) ev_byte <= shreg;
    end
  end

  // An edge arriving in the timeout cycle keeps the frame alive.
  assign timeout = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    ev_good_nxt = 1'b0;
    ev_perr_nxt = 1'b0;
    ev_ferr_nxt = 1'b0;
    tmo_nxt     = (fall || state == IDLE) ? '0 : tmo_cnt + TW'(1);

    if (timeout) begin
      state_nxt   = IDLE;
      ev_ferr_nxt = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            ev_ferr_nxt = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt   = {dat_s2, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = dat_s2;
          state_nxt = STOP;
        end
        STOP: begin
          if (dat_s2 && (^{shreg, par})) ev_good_nxt = 1'b1;
          else if (!dat_s2)              ev_ferr_nxt = 1'b1;
          else                           ev_perr_nxt = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Returns {hit, glyph}; glyphs are {g,f,e,d,c,b,a}, active-low.
  function automatic logic [7:0] glyph_of(input logic [7:0] c);
    case (c)
      8'h45: glyph_of = {1'b1, 7'h40};
      8'h16: glyph_of = {1'b1, 7'h79};
      8'h1E: glyph_of = {1'b1, 7'h24};
      8'h26: glyph_of = {1'b1, 7'h30};
      8'h25: glyph_of = {1'b1, 7'h19};
      8'h2E: glyph_of = {1'b1, 7'h12};
      8'h36: glyph_of = {1'b1, 7'h02};
      8'h3D: glyph_of = {1'b1, 7'h78};
      8'h3E: glyph_of = {1'b1, 7'h00};
      8'h46: glyph_of = {1'b1, 7'h10};
      8'h1C: glyph_of = {1'b1, 7'h08};
      8'h32: glyph_of = {1'b1, 7'h03};
      8'h21: glyph_of = {1'b1, 7'h46};
      8'h23: glyph_of = {1'b1, 7'h21};
      8'h24: glyph_of = {1'b1, 7'h06};
      8'h2B: glyph_of = {1'b1, 7'h0E};
      8'h33: glyph_of = {1'b1, 7'h09};
      8'h4B: glyph_of = {1'b1, 7'h47};
      8'h44: glyph_of = {1'b1, 7'h40};
      8'h4D: glyph_of = {1'b1, 7'h0C};
      8'h3C: glyph_of = {1'b1, 7'h41};
      default: glyph_of = {1'b0, 7'h7F};
    endcase
  endfunction

  logic [GW-1:0] glyph_q, glyph_nxt;
  logic [7:0]    code_q;
  logic          code_valid_q, parity_err_q, frame_err_q;
  logic          brk, ext, brk_nxt, ext_nxt;
  logic [7:0]    map;

  always_comb begin
    map       = glyph_of(ev_byte);
    glyph_nxt = glyph_q;
    brk_nxt   = brk;
    ext_nxt   = ext;
    if (ev_good) begin
      if (ev_byte == 8'hF0) begin
        brk_nxt = 1'b1;
      end else if (ev_byte == 8'hE0) begin
        ext_nxt = 1'b1;
      end else begin
        if (!brk && !ext) begin
          if (ev_byte == 8'h66)      glyph_nxt = {7'h7F, glyph_q[GW-1:7]};
          else if (ev_byte == 8'h29) glyph_nxt = {glyph_q[GW-8:0], 7'h7F};
          else if (map[7])           glyph_nxt = {glyph_q[GW-8:0], map[6:0]};
        end
        brk_nxt = 1'b0;
        ext_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_q      <= '1;
      code_q       <= 8'h00;
      code_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      brk          <= 1'b0;
      ext          <= 1'b0;
    end else begin
      glyph_q      <= glyph_nxt;
      code_valid_q <= ev_good;
      parity_err_q <= ev_perr;
      frame_err_q  <= ev_ferr;
      brk          <= brk_nxt;
      ext          <= ext_nxt;
      if (ev_good) code_q <= ev_byte;
    end
  end

  assign bus.glyph_bus  = glyph_q;
  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_glyph_rx.sv
// Directed bench for ps2_glyph_rx: PS/2 frames driven bit by bit, outputs
// compared against hand-computed codes, glyph buffers and pulse counts.
`timescale 1ns/1ps
module tb_ps2_glyph_rx;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  ps2_glyph_rx_if #(.DIGITS(4)) bus ();

  ps2_glyph_rx #(.TIMEOUT_CYCLES(TMO), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_cv = 0, n_pe = 0, n_fe = 0, n_gchg = 0;
  logic [27:0] prev_glyph = '1;
  logic [27:0] exp_g, lat_old, lat_new;
  int cv0, pe0, fe0, g0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.code_valid) n_cv++;
      if (bus.parity_err) n_pe++;
      if (bus.frame_err)  n_fe++;
      if (bus.glyph_bus !== prev_glyph) n_gchg++;
    end
    prev_glyph = bus.glyph_bus;
  end

  task automatic ps2_bit(input logic v, input bit lat);
    @(posedge clk); #1 bus.ps2_dat = v;
    repeat (HALF) @(posedge clk);
    #1 bus.ps2_clk = 1'b0;
    if (lat) begin
      repeat (3) @(posedge clk);
      #1;
      check("lat_cv_n2", 32'(bus.code_valid), 32'd0);
      check("lat_glyph_n2", 32'(bus.glyph_bus), 32'(lat_old));
      @(posedge clk); #1;
      check("lat_cv_n3", 32'(bus.code_valid), 32'd1);
      check("lat_glyph_n3", 32'(bus.glyph_bus), 32'(lat_new));
      @(posedge clk); #1;
      check("lat_cv_n4", 32'(bus.code_valid), 32'd0);
      repeat (HALF - 5) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    #1 bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic stop_bit, input bit lat);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i], lat && (i == 10));
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
  endtask

  task automatic snap();
    cv0 = n_cv; pe0 = n_pe; fe0 = n_fe; g0 = n_gchg;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_glyph", 32'(bus.glyph_bus), 32'h0FFFFFFF);
    check("rst_code", 32'(bus.code), 32'h00);

    // Reset mid-frame after one good byte
    send_byte(8'h1C);
    repeat (5) @(posedge clk); #1;
    check("pre_rst_glyph", 32'(bus.glyph_bus), 32'({7'h7F, 7'h7F, 7'h7F, 7'h08}));
    send_partial(8'h33, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_glyph", 32'(bus.glyph_bus), 32'h0FFFFFFF);
    check("midrst_code", 32'(bus.code), 32'h00);
    check("midrst_pulses", 32'({bus.code_valid, bus.parity_err, bus.frame_err}), 32'd0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    snap();
    send_byte(8'h45);
    repeat (5) @(posedge clk); #1;
    check("postrst_glyph", 32'(bus.glyph_bus), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
    check("postrst_code", 32'(bus.code), 32'h45);
    check("postrst_fe", 32'(n_fe - fe0), 32'd0);

    // Typing H E L L O with break sequences between keys
    snap();
    send_byte(8'h33); send_byte(8'hF0); send_byte(8'h33);
    send_byte(8'h24); send_byte(8'hF0); send_byte(8'h24);
    send_byte(8'h4B); send_byte(8'hF0); send_byte(8'h4B);
    send_byte(8'h4B); send_byte(8'hF0); send_byte(8'h4B);
    send_byte(8'h44);
    repeat (5) @(posedge clk); #1;
    exp_g = {7'h06, 7'h47, 7'h47, 7'h40};
    check("type_glyph", 32'(bus.glyph_bus), 32'(exp_g));
    check("type_cv_count", 32'(n_cv - cv0), 32'd13);
    check("type_glyph_changes", 32'(n_gchg - g0), 32'd5);
    check("type_code", 32'(bus.code), 32'h44);

    // Backspace, then an extended make code that must not display
    send_byte(8'h66);
    repeat (5) @(posedge clk); #1;
    exp_g = {7'h7F, 7'h06, 7'h47, 7'h47};
    check("bksp_glyph", 32'(bus.glyph_bus), 32'(exp_g));
    snap();
    send_byte(8'hE0); send_byte(8'h75);
    repeat (5) @(posedge clk); #1;
    check("ext_glyph", 32'(bus.glyph_bus), 32'(exp_g));
    check("ext_cv_count", 32'(n_cv - cv0), 32'd2);

    // Even parity on 1C
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("par_pe_count", 32'(n_pe - pe0), 32'd1);
    check("par_cv_count", 32'(n_cv - cv0), 32'd0);
    check("par_code", 32'(bus.code), 32'h75);
    check("par_glyph", 32'(bus.glyph_bus), 32'(exp_g));

    // Stop bit low
    snap();
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk); #1;
    check("stop_fe_count", 32'(n_fe - fe0), 32'd1);
    check("stop_cv_count", 32'(n_cv - cv0), 32'd0);

    // Stall after five data bits until the timeout fires
    snap();
    send_partial(8'h1C, 5);
    repeat (TMO + 100) @(posedge clk); #1;
    check("tmo_fe_count", 32'(n_fe - fe0), 32'd1);
    check("tmo_glyph", 32'(bus.glyph_bus), 32'(exp_g));

    // Next good frame decodes; also measures code_valid latency
    snap();
    lat_old = exp_g;
    lat_new = {7'h06, 7'h47, 7'h47, 7'h79};
    send_frame(8'h16, 1'b0, 1'b1, 1'b1);
    repeat (5) @(posedge clk); #1;
    check("after_tmo_glyph", 32'(bus.glyph_bus), 32'(lat_new));
    check("after_tmo_code", 32'(bus.code), 32'h16);
    check("after_tmo_fe", 32'(n_fe - fe0), 32'd0);
    check("after_tmo_cv", 32'(n_cv - cv0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
